// File: rtl/rst_release_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// rst_release_seq
//
// Reset release sequencer for the 250 MHz parser/book-builder domain.
// Each raw MMCM lock indication is brought into clkIn through its own
// synchronizer. The three downstream stage resets stay asserted until both
// synchronized locks have been high for STABLE_CYCLES consecutive cycles.
// The stages are then released in order: rx handoff, then parsers, then
// book builder, with STAGGER_CYCLES between releases. Any loss of lock once
// the release has started re-asserts every stage reset on the next edge.
//
// Optional feature macro: RST_SEQ_LOSS_CNT_EN
//   defined     -> 8-bit saturating lock-loss event counter on lossCntOut
//   not defined -> no counter logic; lossCntOut is tied to 8'd0
//
// Parameters:
//   STABLE_CYCLES  consecutive locked cycles before the first release (>= 1)
//   STAGGER_CYCLES cycles between successive releases (>= 1)
//   SYNC_DEPTH     flop depth of each lock synchronizer (>= 2)
//
// Ports:
//   clkIn          250 MHz clock
//   rstIn          synchronous active-high reset
//   mmcm0LockedIn  raw MMCM0 locked, asynchronous to clkIn
//   mmcm1LockedIn  raw MMCM1 locked, asynchronous to clkIn
//   rstRxOut       active-high reset, rx handoff stage
//   rstParseOut    active-high reset, parsers
//   rstBookOut     active-high reset, book builder
//   allLockedOut   AND of both synchronized locks
//   stateOut       current FSM state encoding
//   lossCntOut     saturating lock-loss event count
// ----------------------------------------------------------------------------
module rst_release_seq #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int SYNC_DEPTH     = 3
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic       mmcm0LockedIn,
    input  logic       mmcm1LockedIn,
    output logic       rstRxOut,
    output logic       rstParseOut,
    output logic       rstBookOut,
    output logic       allLockedOut,
    output logic [2:0] stateOut,
    output logic [7:0] lossCntOut
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_RX    = 3'd3,
        REL_PARSE = 3'd4,
        RUN       = 3'd5
    } stateT;

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       stageRst;   // {rx, parse, book}, active-high

    logic [SYNC_DEPTH-1:0] lock0Sync;
    logic [SYNC_DEPTH-1:0] lock1Sync;
    logic                  lk;

    // Stage reset pattern for a given state: each stage is released once the
    // sequence has reached that stage's release state, and stays released
    // through every later state.
    function automatic logic [2:0] rstDecode(input stateT s);
        logic [2:0] r;
        r = 3'b111;
        case (s)
            REL_RX:    r = 3'b011;
            REL_PARSE: r = 3'b001;
            RUN:       r = 3'b000;
            default:   r = 3'b111;
        endcase
        return r;
    endfunction

    // Lock synchronizers: raw lock -> synced lock in SYNC_DEPTH edges.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            lock0Sync <= '0;
            lock1Sync <= '0;
        end else begin
            lock0Sync <= {lock0Sync[SYNC_DEPTH-2:0], mmcm0LockedIn};
            lock1Sync <= {lock1Sync[SYNC_DEPTH-2:0], mmcm1LockedIn};
        end
    end

    assign lk = lock0Sync[SYNC_DEPTH-1] & lock1Sync[SYNC_DEPTH-1];

    // Sequencer FSM. Stage resets are registered from the next state so they
    // change on the same edge as the state. A lock drop is tested before the
    // terminal count so a drop on the terminal cycle wins.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state    <= IDLE;
            cnt      <= '0;
            stageRst <= 3'b111;
        end else begin
            case (state)
                IDLE: begin
                    state    <= WAIT_LOCK;
                    cnt      <= '0;
                    stageRst <= rstDecode(WAIT_LOCK);
                end
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (lk) begin
                        state    <= STABLE;
                        stageRst <= rstDecode(STABLE);
                    end else begin
                        stageRst <= rstDecode(WAIT_LOCK);
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        // Glitch before release: restart the qualification
                        // window without counting a loss.
                        state    <= WAIT_LOCK;
                        cnt      <= '0;
                        stageRst <= rstDecode(WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state    <= REL_RX;
                        cnt      <= '0;
                        stageRst <= rstDecode(REL_RX);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REL_RX: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        cnt      <= '0;
                        stageRst <= rstDecode(WAIT_LOCK);
                    end else if (cnt == STAGGER_LAST) begin
                        state    <= REL_PARSE;
                        cnt      <= '0;
                        stageRst <= rstDecode(REL_PARSE);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REL_PARSE: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        cnt      <= '0;
                        stageRst <= rstDecode(WAIT_LOCK);
                    end else if (cnt == STAGGER_LAST) begin
                        state    <= RUN;
                        cnt      <= '0;
                        stageRst <= rstDecode(RUN);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        stageRst <= rstDecode(WAIT_LOCK);
                    end else begin
                        stageRst <= rstDecode(RUN);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    stageRst <= 3'b111;
                end
            endcase
        end
    end

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0] lossCnt;
    logic       lossEvent;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only a drop after release has begun counts; drops while still
    // qualifying in STABLE are treated as glitches.
    assign lossEvent = !lk && ((state == REL_RX) || (state == REL_PARSE) || (state == RUN));

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            lossCnt <= 8'd0;
        end else if (lossEvent) begin
            lossCnt <= satInc(lossCnt);
        end
    end

    assign lossCntOut = lossCnt;
`else
    assign lossCntOut = 8'd0;
`endif

    assign rstRxOut     = stageRst[2];
    assign rstParseOut  = stageRst[1];
    assign rstBookOut   = stageRst[0];
    assign allLockedOut = lk;
    assign stateOut     = state;

endmodule

// File: doc/rst_release_seq.md
# rst_release_seq

Reset release sequencer for the 250 MHz parser/book-builder domain. Consumes the 250 MHz clock and its synchronized reset from the clock/reset generation block, plus both raw MMCM `locked` indications. Holds the downstream stage resets asserted until both MMCMs have been continuously locked for a programmable interval, then releases them in staggered order: rx path, then parsers, then book builder. Re-asserts all stage resets immediately on any loss of lock.

## Interface
- `STABLE_CYCLES`, 1024: consecutive cycles both synced locks must be high before the first release; must be ≥ 1.
- `STAGGER_CYCLES`, 16: cycles between successive releases; must be ≥ 1.
- `SYNC_DEPTH`, 3: flop depth of the per-lock input synchronizers; must be ≥ 2.

Ports:
- `clkIn` in 1: 250 MHz clock (`clk250Out` of the clock block).
- `rstIn` in 1: reset, synchronous to `clkIn`, active-high (`rst250Out`).
- `mmcm0LockedIn` in 1: raw MMCM0 locked; asynchronous.
- `mmcm1LockedIn` in 1: raw MMCM1 locked; asynchronous.
- `rstRxOut` out 1: active-high reset for the rx handoff stage.
- `rstParseOut` out 1: active-high reset for the parsers.
- `rstBookOut` out 1: active-high reset for the book builder.
- `allLockedOut` out 1: AND of both synchronized locks.
- `stateOut` out 3: current FSM state encoding.
- `lossCntOut` out 8: saturating lock-loss event count.

## Operation
- Each lock input passes through a `SYNC_DEPTH` flop chain. Every flop resets to 0 on `rstIn`. `lk` denotes the AND of both synced outputs.
- One counter, width `$clog2(max(STABLE_CYCLES, STAGGER_CYCLES))+1`. It clears on every state change.
- FSM states and `stateOut` encoding:
  - IDLE = 0
  - WAIT_LOCK = 1
  - STABLE = 2
  - REL_RX = 3
  - REL_PARSE = 4
  - RUN = 5
- IDLE: entered on `rstIn`. Goes to WAIT_LOCK on the first edge where `rstIn` is 0.
- WAIT_LOCK: goes to STABLE when `lk` = 1.
- STABLE: the counter increments each cycle.
  - `lk` = 0 returns to WAIT_LOCK. This is not counted as a loss.
  - Counter = `STABLE_CYCLES`−1 with `lk` = 1 goes to REL_RX.
- REL_RX: goes to REL_PARSE after `STAGGER_CYCLES` cycles.
- REL_PARSE: goes to RUN after `STAGGER_CYCLES` cycles.
- RUN: holds while `lk` = 1.
- Lock loss: in REL_RX, REL_PARSE or RUN, `lk` = 0 has priority over the counter. The next state is WAIT_LOCK and `lossCntOut` increments, saturating at 255.
- Outputs are registered and change on the same edge as the state:
  - `rstRxOut` = 0 in {REL_RX, REL_PARSE, RUN}.
  - `rstParseOut` = 0 in {REL_PARSE, RUN}.
  - `rstBookOut` = 0 in RUN.
  - Otherwise each is 1.
- `rstIn` has highest priority in every state. On the next edge: state IDLE, all three resets 1, counter 0, `lossCntOut` 0, synchronizers 0.
- Reset values: `rstRxOut` = `rstParseOut` = `rstBookOut` = 1; `allLockedOut` = 0; `stateOut` = 0; `lossCntOut` = 0.

## Timing
- Raw lock to `lk`: `SYNC_DEPTH` edges. `lk` to STABLE entry: 1 edge.
- `rstRxOut` falls `STABLE_CYCLES` edges after STABLE entry.
- `rstParseOut` falls `STAGGER_CYCLES` edges after `rstRxOut`.
- `rstBookOut` falls `STAGGER_CYCLES` edges after `rstParseOut`.
- Lock loss (synced) to all resets high: 1 edge. From the raw pin, worst case is `SYNC_DEPTH`+1 edges.
- A one-cycle synced lock glitch in STABLE restarts the full `STABLE_CYCLES` count.
- Lock drop and counter terminal count in the same cycle: the drop wins.

## Configuration
- `RST_SEQ_LOSS_CNT_EN` defined: the 8-bit saturating loss counter is implemented as described.
- Not defined: no counter logic is built and `lossCntOut` is tied to 8'd0. The port list is unchanged.

## Test plan
Benches use `STABLE_CYCLES`=8, `STAGGER_CYCLES`=4, `SYNC_DEPTH`=3, macro defined.

- **Clean release:** `rstIn` released, both locks raised and first sampled at edge 1. Expect `allLockedOut`=1 after edge 3, `stateOut`=2 at edge 4, `rstRxOut`=0 at edge 12, `rstParseOut`=0 at edge 16, `rstBookOut`=0 and `stateOut`=5 at edge 20.
- **Glitch in STABLE:** `mmcm1LockedIn` low for 1 cycle while the counter is 5. Expect return to state 1, the full 8-cycle count restarted, `lossCntOut`=0, all resets still 1.
- **Loss in RUN:** `mmcm0LockedIn` dropped in RUN. Expect all resets 1 within 4 edges, `stateOut`=1, `lossCntOut`=1. On relock, the full sequence repeats with the same 8/4/4 spacing.
- **Reset mid-operation:** `rstIn` pulsed for 1 cycle during REL_PARSE. Expect `stateOut`=0, all resets 1, `lossCntOut`=0 on the next edge. The sequence restarts from WAIT_LOCK with synchronizer latency re-incurred.
- **Saturation:** 300 lock-loss events from RUN. Expect `lossCntOut`=255 and held. Rebuilt without the macro, expect `lossCntOut`=0 throughout.
